memory_ram_arbiter: RTL
=======================

# memory_ram_arbiter

Two-port arbiter and sequencer for a home node's directory-state RAM (6-bit state per 16-byte line) and line-data RAM (128-bit), both 128-entry synchronous-read single-port arrays indexed by addr[10:4]. It shares the arrays between the local core miss path (loc) and the ring-network request path (net). It owns every RAM enable, registers all RAM controls, captures synchronous read data and returns it to the winning requester with a per-requester valid pulse.

## Interface
- No parameters; widths fixed: ADDR 32, STATE 6, DATA 128, index addr[10:4].
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- loc_req / net_req  in  1  access request; held with fields stable until granted
- loc_wr / net_wr  in  1  1 = write, 0 = read (read always returns both state and data)
- loc_wmask / net_wmask  in  2  write select: bit0 state RAM, bit1 data RAM
- loc_addr / net_addr  in  32  byte address
- loc_state / net_state  in  6  write state: [3:0] directory, [5:4] home state
- loc_data / net_data  in  128  write data
- loc_gnt / net_gnt  out  1  one-cycle grant pulse
- loc_rvalid / net_rvalid  out  1  one-cycle read-return pulse
- rd_state  out  6  returned state, held until next read return
- rd_data  out  128  returned data, held until next read return
- state_we_out, state_re_out, data_we_out, data_re_out  out  1  RAM enables
- addr_out  out  32  RAM address (full address forwarded; RAM uses [10:4])
- state_wr_out  out  6  state RAM write data
- data_wr_out  out  128  data RAM write data
- ram_state_in  in  6  state RAM read output (valid cycle after re)
- ram_data_in  in  128  data RAM read output (valid cycle after re)

## Operation
- FSM states: IDLE, ACCESS, RDATA.
- IDLE: requests sampled; if any asserted, latch winner id, wr, wmask, addr, state, data; go ACCESS. Otherwise stay, all enables 0.
- ACCESS: registered RAM controls driven from latched fields; winner's gnt = 1.
  - Write: state_we_out = wmask[0], data_we_out = wmask[1]; next IDLE. wmask = 0 is legal: granted, no enable asserted.
  - Read: state_re_out = data_re_out = 1; next RDATA.
- RDATA: capture ram_state_in/ram_data_in into rd_state/rd_data; next IDLE; winner's rvalid asserted in the following cycle.
- Requester must deassert req (or present a new request) in the cycle after its gnt.
- Arbitration is among requests present in IDLE only; a request arriving in ACCESS/RDATA waits.
- Reset values: FSM IDLE, all gnt/rvalid/enables 0, addr_out/state_wr_out/data_wr_out 0, rd_state/rd_data 0, round-robin pointer = loc.
- Reset in ACCESS or RDATA: return to IDLE next cycle, in-flight read discarded, no rvalid issued.

## Timing
- Request sampled in IDLE cycle T; gnt and RAM enables in T+1.
- Write: one access per 2 cycles; back-to-back writes re-grant at T+3.
- Read: RAM data at T+2 (RDATA), rd_state/rd_data/rvalid visible at T+3; next grant earliest T+3 (new request sampled T+2? no — sampled in IDLE at T+3, granted T+4).
- At most one gnt and at most one rvalid asserted in any cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; pointer moves to the non-winner after each grant, so under continuous contention grants alternate loc, net, loc, ...
- Undefined: fixed priority, net always wins over loc (prevents ring back-pressure); loc may starve under continuous net traffic.

## Structure
- Package mem_arb_pkg: FSM state enum, requester-id constants (REQ_LOC = 0, REQ_NET = 1), width constants (ADDR_W 32, STATE_W 6, DATA_W 128, IDX_LSB 4, IDX_MSB 10).
- Sub-module mem_rr_arbiter: 2-way grant selection with pointer, honouring MEM_ARB_RR_EN; FSM, latches and RAM drive stay in the top.

## Test plan
- Single loc write, addr 0x0000_0130, wmask 2'b11, state 6'h15, data 128'hA5..: gnt at T+1 with state_we/data_we = 1, addr_out 0x130; subsequent net read of 0x130 returns rd_state 6'h15, rd_data A5.., net_rvalid 3 cycles after sampling.
- Write with wmask 2'b01 then read: data unchanged, state updated; wmask 2'b00 grants with no enables.
- Continuous loc+net reads with MEM_ARB_RR_EN: grants alternate loc, net, loc, net; without macro: net granted every time.
- Index aliasing: write 0x0000_0810 then read 0x0000_0010 returns same line (bits above [10:4] ignored).
- rst asserted in RDATA: no rvalid, outputs return to reset values, next request serviced normally.
- Idle bus, no requests for 20 cycles: all enables, gnt and rvalid remain 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the directory/data RAM arbiter.
// Holds the FSM state enum, requester ids and fixed field widths.
package mem_arb_pkg;

  localparam int ADDR_W  = 32;
  localparam int STATE_W = 6;
  localparam int DATA_W  = 128;
  localparam int IDX_LSB = 4;
  localparam int IDX_MSB = 10;

  localparam logic REQ_LOC = 1'b0;
  localparam logic REQ_NET = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDATA
  } arb_state_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way grant selection (loc vs net) with a fairness pointer.
// Ports: clk, rst, loc_req, net_req, advance in; win, any out.
// MEM_ARB_RR_EN selects round-robin; otherwise net has fixed priority.
module mem_rr_arbiter
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic loc_req,
  input  logic net_req,
  input  logic advance,
  output logic win,
  output logic any
);

  logic ptr;

  assign any = loc_req | net_req;

`ifdef MEM_ARB_RR_EN
  // Under contention the pointer names the winner.
  always_comb begin
    win = ptr;
    unique case (1'b1)
      loc_req & ~net_req: win = REQ_LOC;
      net_req & ~loc_req: win = REQ_NET;
      default:            win = ptr;
    endcase
  end
`else
  // Net always wins; the pointer only fills the no-request case.
  always_comb begin
    win = ptr;
    unique case (1'b1)
      net_req:            win = REQ_NET;
      loc_req & ~net_req: win = REQ_LOC;
      default:            win = ptr;
    endcase
  end
`endif

  // Hand priority to the loser after every grant.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= REQ_LOC;
    else if (advance)
      ptr <= ~win;
  end

endmodule

// File: rtl/memory_ram_arbiter.sv
// Arbiter/sequencer sharing the directory-state and line-data RAMs
// between the local miss path (loc) and the ring request path (net).
// Ports: per-requester req/wr/wmask/addr/state/data in, gnt/rvalid out;
// rd_state/rd_data return; registered RAM enables, addr and write data;
// ram_state_in/ram_data_in sync-read returns. Option: MEM_ARB_RR_EN.
module memory_ram_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               loc_req,
  input  logic               loc_wr,
  input  logic [1:0]         loc_wmask,
  input  logic [ADDR_W-1:0]  loc_addr,
  input  logic [STATE_W-1:0] loc_state,
  input  logic [DATA_W-1:0]  loc_data,
  input  logic               net_req,
  input  logic               net_wr,
  input  logic [1:0]         net_wmask,
  input  logic [ADDR_W-1:0]  net_addr,
  input  logic [STATE_W-1:0] net_state,
  input  logic [DATA_W-1:0]  net_data,
  output logic               loc_gnt,
  output logic               net_gnt,
  output logic               loc_rvalid,
  output logic               net_rvalid,
  output logic [STATE_W-1:0] rd_state,
  output logic [DATA_W-1:0]  rd_data,
  output logic               state_we_out,
  output logic               state_re_out,
  output logic               data_we_out,
  output logic               data_re_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [STATE_W-1:0] state_wr_out,
  output logic [DATA_W-1:0]  data_wr_out,
  input  logic [STATE_W-1:0] ram_state_in,
  input  logic [DATA_W-1:0]  ram_data_in
);

  arb_state_t state, next_state;

  logic win, any, take;
  logic win_q, wr_q;

  logic               sel_wr;
  logic [1:0]         sel_wmask;
  logic [ADDR_W-1:0]  sel_addr;
  logic [STATE_W-1:0] sel_state;
  logic [DATA_W-1:0]  sel_data;

  mem_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .loc_req (loc_req),
    .net_req (net_req),
    .advance (take),
    .win     (win),
    .any     (any)
  );

  always_comb begin
    sel_wr    = loc_wr;
    sel_wmask = loc_wmask;
    sel_addr  = loc_addr;
    sel_state = loc_state;
    sel_data  = loc_data;
    if (win == REQ_NET) begin
      sel_wr    = net_wr;
      sel_wmask = net_wmask;
      sel_addr  = net_addr;
      sel_state = net_state;
      sel_data  = net_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          take       = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS:  next_state = wr_q ? IDLE : RDATA;
      RDATA:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Controls are loaded on the sampling edge so they appear
  // registered in the ACCESS cycle; pulses self-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q        <= REQ_LOC;
      wr_q         <= 1'b0;
      loc_gnt      <= 1'b0;
      net_gnt      <= 1'b0;
      loc_rvalid   <= 1'b0;
      net_rvalid   <= 1'b0;
      state_we_out <= 1'b0;
      state_re_out <= 1'b0;
      data_we_out  <= 1'b0;
      data_re_out  <= 1'b0;
      addr_out     <= '0;
      state_wr_out <= '0;
      data_wr_out  <= '0;
      rd_state     <= '0;
      rd_data      <= '0;
    end else begin
      loc_gnt      <= 1'b0;
      net_gnt      <= 1'b0;
      loc_rvalid   <= 1'b0;
      net_rvalid   <= 1'b0;
      state_we_out <= 1'b0;
      state_re_out <= 1'b0;
      data_we_out  <= 1'b0;
      data_re_out  <= 1'b0;
      if (take) begin
        win_q        <= win;
        wr_q         <= sel_wr;
        addr_out     <= sel_addr;
        state_wr_out <= sel_state;
        data_wr_out  <= sel_data;
        loc_gnt      <= (win == REQ_LOC);
        net_gnt      <= (win == REQ_NET);
        state_we_out <= sel_wr & sel_wmask[0];
        data_we_out  <= sel_wr & sel_wmask[1];
        state_re_out <= ~sel_wr;
        data_re_out  <= ~sel_wr;
      end
      if (state == RDATA) begin
        rd_state   <= ram_state_in;
        rd_data    <= ram_data_in;
        loc_rvalid <= (win_q == REQ_LOC);
        net_rvalid <= (win_q == REQ_NET);
      end
    end
  end

endmodule
